// File: rtl/led_status_sequencer.sv
// LED status sequencer: error-code blink, busy alternation or idle pattern, registered and active-low.
// Optional macro LED_SCAN_EN swaps the idle binary count for a one-hot bounce scan.
module led_status_sequencer #(
  parameter int              WIDTH        = 6,
  parameter int              GAP_TICKS    = 4,
  parameter int              SYNC_STAGES  = 2,
  parameter logic [WIDTH-1:0] BUSY_PATTERN = 6'b101010
) (
  input  logic             led_clock,
  input  logic             RST,
  input  logic             sd_busy,
  input  logic             sd_error,
  input  logic [3:0]       sd_err_code,
  output logic [WIDTH-1:0] led_n,
  output logic             err_latched,
  output logic [2:0]       state_dbg
);
  localparam int GW = $clog2(GAP_TICKS + 1);

  typedef enum logic [2:0] {
    S_COUNT   = 3'd0,
    S_BUSY    = 3'd1,
    S_ERR_ON  = 3'd2,
    S_ERR_OFF = 3'd3,
    S_ERR_GAP = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] busy_sync_q, busy_sync_d;
  logic [SYNC_STAGES-1:0] err_sync_q, err_sync_d;
  logic                   err_prev_q, err_prev_d;
  logic                   err_rise_q, err_rise_d;
  logic [4:0]             target_q, target_d;
  logic [4:0]             blink_cnt_q, blink_cnt_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic                   err_latched_q, err_latched_d;
  logic [WIDTH-1:0]       led_n_q, led_n_d;
  logic [WIDTH-1:0]       pattern;
  logic                   busy_s, err_s, rise_pending;
`ifdef LED_SCAN_EN
  logic [WIDTH-1:0]       pos_q, pos_d, pos_step;
  logic                   dir_q, dir_d, dir_step;
`else
  logic [WIDTH-1:0]       count_q, count_d;
`endif

  assign busy_s       = busy_sync_q[SYNC_STAGES-1];
  assign err_s        = err_sync_q[SYNC_STAGES-1];
  assign rise_pending = err_s & ~err_prev_q;

`ifdef LED_SCAN_EN
  // dir 0 moves towards the MSB; the end positions turn around without repeating
  always_comb begin
    pos_step = pos_q;
    dir_step = dir_q;
    if (!dir_q) begin
      if (pos_q[WIDTH-1]) begin
        dir_step = 1'b1;
        pos_step = pos_q >> 1;
      end else begin
        pos_step = pos_q << 1;
      end
    end else begin
      if (pos_q[0]) begin
        dir_step = 1'b0;
        pos_step = pos_q << 1;
      end else begin
        pos_step = pos_q >> 1;
      end
    end
  end
`endif

  always_comb begin
    busy_sync_d   = {busy_sync_q[SYNC_STAGES-2:0], sd_busy};
    err_sync_d    = {err_sync_q[SYNC_STAGES-2:0], sd_error};
    err_prev_d    = err_s;
    err_rise_d    = rise_pending;
    state_d       = state_q;
    target_d      = target_q;
    blink_cnt_d   = blink_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    err_latched_d = err_latched_q;
    pattern       = '0;
`ifdef LED_SCAN_EN
    pos_d         = pos_q;
    dir_d         = dir_q;
`else
    count_d       = count_q;
`endif
    case (state_q)
      S_COUNT, S_BUSY: begin
        if (err_rise_q) begin
          state_d       = S_ERR_ON;
          err_latched_d = 1'b1;
          target_d      = (sd_err_code == 4'd0) ? 5'd16 : {1'b0, sd_err_code};
          blink_cnt_d   = 5'd0;
          pattern       = '1;
        end else if (state_q == S_COUNT) begin
          // A rise still in the edge-detect flop outranks a busy that arrived alongside it
          if (busy_s && !rise_pending) begin
            state_d = S_BUSY;
            pattern = BUSY_PATTERN;
          end else begin
`ifdef LED_SCAN_EN
            pos_d   = pos_step;
            dir_d   = dir_step;
            pattern = pos_step;
`else
            count_d = count_q + WIDTH'(1);
            pattern = count_d;
`endif
          end
        end else begin
          if (busy_s) begin
            pattern = led_n_q;
          end else begin
            state_d = S_COUNT;
`ifdef LED_SCAN_EN
            pattern = pos_q;
`else
            pattern = count_q;
`endif
          end
        end
      end
      S_ERR_ON: begin
        blink_cnt_d = blink_cnt_q + 5'd1;
        state_d     = S_ERR_OFF;
      end
      S_ERR_OFF: begin
        if (blink_cnt_q == target_q) begin
          blink_cnt_d = 5'd0;
          gap_cnt_d   = '0;
          state_d     = S_ERR_GAP;
        end else begin
          state_d = S_ERR_ON;
          pattern = '1;
        end
      end
      S_ERR_GAP: begin
        if (gap_cnt_q == GW'(GAP_TICKS - 1)) begin
          state_d = S_ERR_ON;
          pattern = '1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = S_COUNT;
    endcase
    led_n_d = ~pattern;
  end

  always_ff @(posedge led_clock or posedge RST) begin
    if (RST) begin
      state_q       <= S_COUNT;
      busy_sync_q   <= '0;
      err_sync_q    <= '0;
      err_prev_q    <= 1'b0;
      err_rise_q    <= 1'b0;
      target_q      <= 5'd0;
      blink_cnt_q   <= 5'd0;
      gap_cnt_q     <= '0;
      err_latched_q <= 1'b0;
      led_n_q       <= '1;
`ifdef LED_SCAN_EN
      pos_q         <= WIDTH'(1);
      dir_q         <= 1'b0;
`else
      count_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      busy_sync_q   <= busy_sync_d;
      err_sync_q    <= err_sync_d;
      err_prev_q    <= err_prev_d;
      err_rise_q    <= err_rise_d;
      target_q      <= target_d;
      blink_cnt_q   <= blink_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      err_latched_q <= err_latched_d;
      led_n_q       <= led_n_d;
`ifdef LED_SCAN_EN
      pos_q         <= pos_d;
      dir_q         <= dir_d;
`else
      count_q       <= count_d;
`endif
    end
  end

  assign led_n       = led_n_q;
  assign err_latched = err_latched_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_led_status_sequencer.sv
// Directed bench for led_status_sequencer: idle count wrap, busy freeze/resume, error blink bursts,
// sticky error, asynchronous reset and simultaneous busy/error. Expected idle values follow LED_SCAN_EN.
module tb_led_status_sequencer;
  logic       led_clock = 1'b0;
  logic       RST = 1'b1;
  logic       sd_busy = 1'b0;
  logic       sd_error = 1'b0;
  logic [3:0] sd_err_code = 4'd0;
  logic [5:0] led_n;
  logic       err_latched;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;
  int n = 0;

  led_status_sequencer dut (
    .led_clock  (led_clock),
    .RST        (RST),
    .sd_busy    (sd_busy),
    .sd_error   (sd_error),
    .sd_err_code(sd_err_code),
    .led_n      (led_n),
    .err_latched(err_latched),
    .state_dbg  (state_dbg)
  );

  always #5 led_clock = ~led_clock;

  // Idle pattern after n idle steps from reset
  function automatic logic [5:0] dispPat(input int steps);
`ifdef LED_SCAN_EN
    int m;
    int p;
    logic [5:0] one;
    m   = steps % 10;
    p   = (m <= 5) ? m : 10 - m;
    one = 6'd1;
    return one << p;
`else
    return 6'(steps);
`endif
  endfunction

  task automatic tick();
    @(posedge led_clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #12;
    checkOutput("reset_led_n", {2'b0, led_n}, 8'h3f);
    checkOutput("reset_err_latched", {7'b0, err_latched}, 8'h0);
    checkOutput("reset_state", {5'b0, state_dbg}, 8'h0);
    #10 RST = 1'b0;

    // idle count over 64 ticks, wrapping back to all LEDs off
    for (int i = 1; i <= 64; i++) begin
      tick();
      n = i;
      checkOutput($sformatf("idle_%0d", i), {2'b0, led_n}, {2'b0, ~dispPat(n)});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n++;
      checkOutput("idle_pre_busy", {2'b0, led_n}, {2'b0, ~dispPat(n)});
    end

    // busy: two sync edges still idle, then alternation, then resume at the frozen value
    sd_busy = 1'b1;
    tick(); n++;
    checkOutput("busy_lat_a", {2'b0, led_n}, {2'b0, ~dispPat(n)});
    tick(); n++;
    checkOutput("busy_lat_b", {2'b0, led_n}, {2'b0, ~dispPat(n)});
    tick();
    checkOutput("busy_first", {2'b0, led_n}, 8'h15);
    checkOutput("busy_state", {5'b0, state_dbg}, 8'h1);
    tick();
    checkOutput("busy_second", {2'b0, led_n}, 8'h2a);
    tick();
    checkOutput("busy_third", {2'b0, led_n}, 8'h15);
    sd_busy = 1'b0;
    tick();
    checkOutput("busy_drop_a", {2'b0, led_n}, 8'h2a);
    tick();
    checkOutput("busy_drop_b", {2'b0, led_n}, 8'h15);
    tick();
    checkOutput("resume_frozen", {2'b0, led_n}, {2'b0, ~dispPat(n)});
    checkOutput("resume_state", {5'b0, state_dbg}, 8'h0);
    tick(); n++;
    checkOutput("resume_next", {2'b0, led_n}, {2'b0, ~dispPat(n)});

    // error code 3: three idle edges of latency, then bursts of period 10
    sd_error = 1'b1;
    sd_err_code = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick(); n++;
      checkOutput("err_latency", {2'b0, led_n}, {2'b0, ~dispPat(n)});
    end
    checkOutput("err_not_yet_latched", {7'b0, err_latched}, 8'h0);
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (k == 0) begin
        checkOutput("err_state_on", {5'b0, state_dbg}, 8'h2);
        sd_error = 1'b0;
      end
      if (k == 5) begin
        sd_error = 1'b1;
        sd_err_code = 4'd1;
      end
      checkOutput($sformatf("err3_k%0d", k), {2'b0, led_n},
                  ((k % 10) < 6 && (k % 2) == 0) ? 8'h00 : 8'h3f);
      checkOutput("err_latched_sticky", {7'b0, err_latched}, 8'h1);
    end

    // asynchronous reset in S_ERR_ON
    sd_error = 1'b0;
    #2 RST = 1'b1;
    #1;
    checkOutput("async_rst_led_n", {2'b0, led_n}, 8'h3f);
    checkOutput("async_rst_err_latched", {7'b0, err_latched}, 8'h0);
    checkOutput("async_rst_state", {5'b0, state_dbg}, 8'h0);
    #3 RST = 1'b0;
    n = 0;
    for (int i = 0; i < 2; i++) begin
      tick(); n++;
      checkOutput("post_rst_count", {2'b0, led_n}, {2'b0, ~dispPat(n)});
    end

    // simultaneous busy and error with code 0: busy never shown, 16 blinks per burst
    sd_busy = 1'b1;
    sd_error = 1'b1;
    sd_err_code = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick(); n++;
      checkOutput("sim_latency", {2'b0, led_n}, {2'b0, ~dispPat(n)});
      checkOutput("sim_no_busy", {5'b0, state_dbg}, 8'h0);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      checkOutput($sformatf("err0_k%0d", k), {2'b0, led_n},
                  ((k % 36) < 32 && (k % 2) == 0) ? 8'h00 : 8'h3f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
